// File: rtl/fifoc2mac.sv
// Transmit bridge: pulls a programmed number of bytes from the device FIFO into the
// MAC UDP transmit buffer, then requests a frame and reports done to the control FSM.
module fifoc2mac (
   input  logic        clk,
   input  logic        rst,
   input  logic        fs,
   output logic        fd,
   output logic [3:0]  so,
   input  logic [7:0]  fifoc_rxd,
   output logic        fifoc_rxen,
   input  logic        fifoc_empty,
   input  logic [11:0] dev_tx_len,
   output logic [7:0]  udp_txd,
   output logic [10:0] udp_tx_addr,
   output logic        udp_tx_en,
   output logic [15:0] udp_tx_len,
   output logic        udp_tx_req,
   input  logic        udp_tx_ack
);

   localparam logic [11:0] MaxLen = 12'd1472;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWork = 3'd1,
      StTail = 3'd2,
      StSend = 3'd3,
      StLast = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [11:0] reg_len_q, reg_len_d;
   logic [11:0] rd_cnt_q, rd_cnt_d;
   logic [10:0] tx_addr_q, tx_addr_d;
   logic        tx_en_q, tx_en_d;
   logic [15:0] tx_len_q, tx_len_d;
   logic [11:0] sat_len;

   assign sat_len = (dev_tx_len > MaxLen) ? MaxLen : dev_tx_len;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (fs) begin
               state_d = (dev_tx_len == 12'd0) ? StLast : StWork;
            end
         end
         StWork: begin
            if (fifoc_rxen && (rd_cnt_q == reg_len_q - 12'd1)) begin
               state_d = StTail;
            end
         end
         StTail: state_d = StSend;
         StSend: begin
            if (udp_tx_ack) begin
               state_d = StLast;
            end
         end
         StLast: begin
            if (!fs) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      so         = {1'b0, state_q};
      fd         = (state_q == StLast);
      fifoc_rxen = (state_q == StWork) && !fifoc_empty;
      udp_tx_req = (state_q == StSend);
   end

   always_comb begin
      reg_len_d = reg_len_q;
      tx_len_d  = tx_len_q;
      rd_cnt_d  = rd_cnt_q;
      tx_addr_d = tx_addr_q;
      tx_en_d   = fifoc_rxen;
      if (state_q == StIdle) begin
         rd_cnt_d  = 12'd0;
         tx_addr_d = 11'd0;
         if (fs) begin
            reg_len_d = sat_len;
            tx_len_d  = {4'h0, sat_len} + 16'h8;
         end
      end else begin
         if (fifoc_rxen) begin
            rd_cnt_d = rd_cnt_q + 12'd1;
         end
         // Address advances after the write it labelled, so byte k lands at k.
         if (tx_en_q) begin
            tx_addr_d = tx_addr_q + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_len_q <= 12'd0;
         rd_cnt_q  <= 12'd0;
         tx_addr_q <= 11'd0;
         tx_en_q   <= 1'b0;
         tx_len_q  <= 16'h0008;
      end else begin
         reg_len_q <= reg_len_d;
         rd_cnt_q  <= rd_cnt_d;
         tx_addr_q <= tx_addr_d;
         tx_en_q   <= tx_en_d;
         tx_len_q  <= tx_len_d;
      end
   end

   assign udp_txd     = fifoc_rxd;
   assign udp_tx_en   = tx_en_q;
   assign udp_tx_addr = tx_addr_q;
   assign udp_tx_len  = tx_len_q;

endmodule

// File: tb/tb_fifoc2mac.sv
// Directed bench for fifoc2mac: FIFO and MAC buffer models plus a vector table
// of transfers and hand-written reset / spurious-ack sequences.
module tb_fifoc2mac;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fs = 1'b0;
   logic        fd;
   logic [3:0]  so;
   logic [7:0]  fifoc_rxd = 8'h00;
   logic        fifoc_rxen;
   logic        fifoc_empty;
   logic [11:0] dev_tx_len = 12'd0;
   logic [7:0]  udp_txd;
   logic [10:0] udp_tx_addr;
   logic        udp_tx_en;
   logic [15:0] udp_tx_len;
   logic        udp_tx_req;
   logic        udp_tx_ack = 1'b0;

   int tests = 0;
   int fails = 0;

   fifoc2mac dut (
      .clk(clk), .rst(rst), .fs(fs), .fd(fd), .so(so),
      .fifoc_rxd(fifoc_rxd), .fifoc_rxen(fifoc_rxen), .fifoc_empty(fifoc_empty),
      .dev_tx_len(dev_tx_len), .udp_txd(udp_txd), .udp_tx_addr(udp_tx_addr),
      .udp_tx_en(udp_tx_en), .udp_tx_len(udp_tx_len), .udp_tx_req(udp_tx_req),
      .udp_tx_ack(udp_tx_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int k);
      logic [7:0] kk;
      kk = 8'(k + 1);
      return 8'(kk * 8'h11);
   endfunction

   // FIFO model: data appears one cycle after a read enable
   logic [7:0] mem [0:4095];
   int  wr_ptr = 0;
   int  rd_ptr = 0;
   logic stall = 1'b0;
   assign fifoc_empty = (wr_ptr == rd_ptr) || stall;

   always @(posedge clk) begin
      if (fifoc_rxen && !fifoc_empty) begin
         fifoc_rxd <= mem[rd_ptr % 4096];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Monitor of reads, buffer writes and requests
   logic mon_clr = 1'b0;
   int   rcnt = 0;
   int   wcnt = 0;
   int   werr = 0;
   int   reqcnt = 0;
   int   last_addr = -1;

   always @(posedge clk) begin
      if (mon_clr) begin
         rcnt <= 0; wcnt <= 0; werr <= 0; reqcnt <= 0; last_addr <= -1;
      end else begin
         if (fifoc_rxen) rcnt <= rcnt + 1;
         if (udp_tx_req) reqcnt <= reqcnt + 1;
         if (udp_tx_en) begin
            if (udp_tx_addr != 11'(wcnt) || udp_txd != pat(wcnt)) werr <= werr + 1;
            wcnt      <= wcnt + 1;
            last_addr <= int'(udp_tx_addr);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic prep(input int n);
      wr_ptr = rd_ptr;
      for (int i = 0; i < n; i++) begin
         mem[(wr_ptr + i) % 4096] = pat(i);
      end
      wr_ptr = wr_ptr + n;
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic wait_so(input string name, input int target, input int budget);
      int n = 0;
      while (int'(so) != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(so), target);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_so"}, int'(so), 0);
      chk({tag, "_fd"}, int'(fd), 0);
      chk({tag, "_rxen"}, int'(fifoc_rxen), 0);
      chk({tag, "_txen"}, int'(udp_tx_en), 0);
      chk({tag, "_addr"}, int'(udp_tx_addr), 0);
      chk({tag, "_req"}, int'(udp_tx_req), 0);
      chk({tag, "_txlen"}, int'(udp_tx_len), 8);
   endtask

   typedef struct {
      int len;
      int ack_dly;
      int stall_at;
      int stall_n;
      int exp_n;
      int exp_txlen;
   } vec_t;

   task automatic run_xfer(input vec_t v);
      bit stalled = 0;
      int n = 0;
      prep(v.exp_n);
      fs = 1'b1;
      dev_tx_len = 12'(v.len);
      @(negedge clk);
      chk("enter_work", int'(so), 1);
      while (int'(so) != 3 && n < 4000) begin
         if (!stalled && v.stall_n > 0 && rcnt == v.stall_at) begin
            stalled = 1;
            stall = 1'b1;
            for (int i = 0; i < v.stall_n; i++) begin
               @(negedge clk);
               if (int'(so) != 1 || rcnt != v.stall_at) chk("stall_hold", rcnt, v.stall_at);
            end
            chk("stall_so", int'(so), 1);
            stall = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      chk("reach_send", int'(so), 3);
      chk("req_send", int'(udp_tx_req), 1);
      chk("txlen_send", int'(udp_tx_len), v.exp_txlen);
      for (int i = 0; i < v.ack_dly; i++) begin
         @(negedge clk);
         if (udp_tx_req != 1'b1) chk("req_hold", int'(udp_tx_req), 1);
      end
      udp_tx_ack = 1'b1;
      @(negedge clk);
      udp_tx_ack = 1'b0;
      chk("last_so", int'(so), 4);
      chk("last_fd", int'(fd), 1);
      chk("last_req", int'(udp_tx_req), 0);
      chk("txlen_last", int'(udp_tx_len), v.exp_txlen);
      fs = 1'b0;
      @(negedge clk);
      chk("idle_so", int'(so), 0);
      chk("idle_fd", int'(fd), 0);
      chk("reads", rcnt, v.exp_n);
      chk("writes", wcnt, v.exp_n);
      chk("last_addr", last_addr, v.exp_n - 1);
      chk("write_data_addr", werr, 0);
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = '{len: 4,    ack_dly: 3, stall_at: 0, stall_n: 0, exp_n: 4,    exp_txlen: 12};
      vecs[1] = '{len: 6,    ack_dly: 1, stall_at: 2, stall_n: 5, exp_n: 6,    exp_txlen: 14};
      vecs[2] = '{len: 2000, ack_dly: 0, stall_at: 0, stall_n: 0, exp_n: 1472, exp_txlen: 1480};
      vecs[3] = '{len: 1,    ack_dly: 2, stall_at: 0, stall_n: 0, exp_n: 1,    exp_txlen: 9};
      vecs[4] = '{len: 7,    ack_dly: 0, stall_at: 3, stall_n: 2, exp_n: 7,    exp_txlen: 15};

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");

      for (int i = 0; i < 5; i++) begin
         run_xfer(vecs[i]);
      end

      // Zero length: straight to LAST, no reads, no request
      prep(0);
      fs = 1'b1;
      dev_tx_len = 12'd0;
      @(negedge clk);
      chk("zero_so", int'(so), 4);
      chk("zero_fd", int'(fd), 1);
      fs = 1'b0;
      @(negedge clk);
      chk("zero_idle", int'(so), 0);
      chk("zero_reads", rcnt, 0);
      chk("zero_req", reqcnt, 0);

      // Reset during WORK at byte 3 of 10, then a fresh 2-byte transfer
      prep(10);
      fs = 1'b1;
      dev_tx_len = 12'd10;
      @(negedge clk);
      begin
         int n = 0;
         while (rcnt < 3 && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("rst_at_byte", rcnt, 3);
      fs = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_xfer('{len: 2, ack_dly: 1, stall_at: 0, stall_n: 0, exp_n: 2, exp_txlen: 10});

      // Spurious ack in WORK and fs dropped in SEND are both ignored
      prep(3);
      fs = 1'b1;
      dev_tx_len = 12'd3;
      @(negedge clk);
      udp_tx_ack = 1'b1;
      @(negedge clk);
      udp_tx_ack = 1'b0;
      chk("ack_in_work", int'(so), 1);
      wait_so("ign_send", 3, 20);
      fs = 1'b0;
      repeat (3) @(negedge clk);
      chk("fs_drop_send", int'(so), 3);
      chk("fs_drop_req", int'(udp_tx_req), 1);
      udp_tx_ack = 1'b1;
      @(negedge clk);
      udp_tx_ack = 1'b0;
      chk("ign_last", int'(so), 4);
      chk("ign_fd", int'(fd), 1);
      @(negedge clk);
      chk("ign_idle", int'(so), 0);
      chk("ign_writes", wcnt, 3);
      chk("ign_data", werr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifoc2mac.md
# fifoc2mac

Transmit-side bridge between the device FIFO and the UDP MAC. On a start request from the control FSM, it reads a programmed number of payload bytes out of the FIFO, writes them byte-by-byte into the MAC UDP transmit buffer, and requests a frame transmission. It reports completion back to the control FSM with the same `fs`/`fd`/`so` handshake used by the receive bridge.

## Interface
No parameters; widths fixed.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `fs`  in  1  start request from control FSM (level)
- `fd`  out  1  done; high in LAST
- `so`  out  4  current state code
- `fifoc_rxd`  in  8  FIFO read data, valid 1 cycle after `fifoc_rxen`
- `fifoc_rxen`  out  1  FIFO read enable
- `fifoc_empty`  in  1  FIFO empty flag
- `dev_tx_len`  in  12  payload byte count to send
- `udp_txd`  out  8  MAC tx buffer write data
- `udp_tx_addr`  out  11  MAC tx buffer write address
- `udp_tx_en`  out  1  MAC tx buffer write strobe
- `udp_tx_len`  out  16  UDP length (payload + 8)
- `udp_tx_req`  out  1  transmit request to MAC
- `udp_tx_ack`  in  1  MAC accepted request

## Operation
- States and codes on `so`: IDLE=0, WORK=1, TAIL=2, SEND=3, LAST=4.
- IDLE:
  - `fs`=1 and `dev_tx_len`≠0: latch the length into `reg_len`, then go to WORK.
  - `fs`=1 and `dev_tx_len`=0: go straight to LAST. No FIFO reads, no request.
  - Length saturation: `dev_tx_len` > 1472 latches as 1472.
- WORK:
  - `fifoc_rxen` = (state==WORK) & !`fifoc_empty`. This is combinational.
  - 12-bit `rd_cnt` clears on entry and increments on each cycle with `fifoc_rxen`=1.
  - Leave for TAIL on the cycle where `fifoc_rxen`=1 and `rd_cnt`==`reg_len`-1.
  - Empty FIFO stalls the read. The count does not advance and the state is held.
- TAIL: single cycle to absorb the final FIFO read latency; then go to SEND.
- SEND: `udp_tx_req`=1. On `udp_tx_ack`=1, go to LAST.
- LAST: `fd`=1. On `fs`=0, go to IDLE.
- Write path:
  - `udp_txd` = `fifoc_rxd` (passthrough).
  - `udp_tx_en` is `fifoc_rxen` registered one cycle.
  - `udp_tx_addr` clears to 0 in IDLE and increments after each cycle with `udp_tx_en`=1. First byte goes to address 0 and byte k to address k.
- `udp_tx_len` = {4'h0,`reg_len`} + 16'h8. It is registered and stable from WORK through LAST; IDLE value is 16'h8 after reset.
- `fs` falling before LAST is ignored; the transfer always completes.
- `udp_tx_ack` outside SEND is ignored.

## Timing
- Reset values: state IDLE, `so`=0, `fd`=0, `fifoc_rxen`=0, `udp_tx_en`=0, `udp_tx_addr`=0, `udp_tx_req`=0, `udp_tx_len`=16'h0008, `reg_len`=0, `rd_cnt`=0.
- Reset mid-transfer aborts immediately to the reset values. FIFO contents are not restored.
- Cycle sequence with FIFO never empty and `fs` rising seen at edge T0:
  - WORK over cycles T0+1..T0+N, with `fifoc_rxen` high throughout.
  - `udp_tx_en` high over T0+2..T0+N+1, with addresses 0..N-1.
  - TAIL at T0+N+1, which carries the last write.
  - SEND from T0+N+2.
- `udp_tx_req` asserts the cycle after entering SEND, or combinationally from state; either is acceptable as long as it is held until ack. It drops the cycle after `udp_tx_ack` is sampled.
- `fd` rises one cycle after ack. It falls one cycle after `fs`=0 is sampled in LAST.
- Exactly `reg_len` FIFO reads and `reg_len` buffer writes per transfer, regardless of stalls.

## Test plan
- `dev_tx_len`=4, FIFO holds 11,22,33,44, ack 3 cycles after req -> four writes at addresses 0..3 with data 11,22,33,44; `udp_tx_len`=12; `fd`=1 after ack; then `fs`=0 gives IDLE.
- `dev_tx_len`=6, `fifoc_empty` high for 5 cycles after the 2nd read -> `rd_cnt` and `so`=1 held; 6 reads and 6 writes total; addresses contiguous 0..5.
- `dev_tx_len`=0 with `fs`=1 -> `so` goes 0 to 4 directly; no `fifoc_rxen`, no `udp_tx_req`; `fd`=1.
- `dev_tx_len`=2000 -> exactly 1472 reads; last address 1471; `udp_tx_len`=1480.
- `rst` pulsed while in WORK at byte 3 of 10 -> all outputs return to reset values next cycle. A new `fs` with length 2 then writes addresses 0..1.
- `udp_tx_ack` pulsed during WORK and `fs` dropped in SEND -> both ignored; module remains in SEND until a real ack, then enters LAST and immediately returns to IDLE since `fs`=0.
